// File: rtl/ext_bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// ext_bus_arb_pkg
// Shared definitions for the external bus arbiter: arbiter state encoding,
// default timeout and fetch address offset, memory op-codes and the
// grant-owner type used for fairness tracking.
// ---------------------------------------------------------------------------
package ext_bus_arb_pkg;

    // Cycles to wait for m_ack before a transfer is aborted.
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    // Offset added to every instruction-fetch address on the external bus.
    localparam logic [31:0] DEFAULT_PC_EXT_BASE = 32'h0000_0800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IXFER = 2'd1,
        DXFER = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Memory op-codes carried on d_we / m_we.
    typedef enum logic {
        MEM_OP_LOAD  = 1'b0,
        MEM_OP_STORE = 1'b1
    } mem_op_e;

    // Which requester owned the most recent grant.
    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

endpackage

// File: rtl/ext_bus_arb_if.sv
// ---------------------------------------------------------------------------
// ext_bus_arb_if
// External bus between the arbiter (master) and the memory system (slave).
//   m_req    command valid, held until the cycle after m_ack
//   m_we     1 = store, 0 = load/fetch
//   m_addr   byte address
//   m_wdata  store data
//   m_wstrb  store byte enables (zero for loads and fetches)
//   m_ack    one-cycle response from the slave
//   m_rdata  read data, valid with m_ack
// ---------------------------------------------------------------------------
interface ext_bus_arb_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/ext_bus_arb_bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer
// Wait counter for an outstanding external bus transfer.
//   clk, rst  clock and asynchronous active-high reset
//   clear     synchronous clear (held while no transfer is in flight)
//   enable    count one cycle of waiting
//   expired   high during the LIMIT-th enabled cycle since the last clear
// ---------------------------------------------------------------------------
module bus_timer
    import ext_bus_arb_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // The first enabled cycle sees count = 0, so the LIMIT-th sees LIMIT-1.
    assign expired = (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ext_bus_arb.sv
// ---------------------------------------------------------------------------
// ext_bus_arb
// Arbitrates an instruction-fetch port and a data port onto one external
// bus. One transfer at a time; data normally wins, but a fetch wins a tie
// when the previous grant went to data, so fetches cannot starve.
//   clk, rst            clock, asynchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ack)
//   i_ack/i_rdata       one-cycle fetch completion and fetched word
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb     data request (held until d_ack)
//   d_ack/d_rdata       one-cycle data completion and load data
//   err                 high with the ack of a transfer that timed out
//   bus                 external bus, master side
// ---------------------------------------------------------------------------
module ext_bus_arb
    import ext_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter logic [31:0] PC_EXT_BASE = DEFAULT_PC_EXT_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic                 i_ack,
    output logic [31:0]          i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    input  logic [3:0]           d_wstrb,
    output logic                 d_ack,
    output logic [31:0]          d_rdata,
    output logic                 err,
    ext_bus_arb_if.master        bus
);

    arb_state_e state;
    grant_e     last_grant;
    logic       in_xfer;
    logic       expired;
    logic       grant_data;

    assign in_xfer = (state == IXFER) || (state == DXFER);

    // Data has priority unless it also took the previous grant and a fetch
    // is waiting.
    assign grant_data = d_req && !(i_req && (last_grant == GRANT_DATA));

    bus_timer #(
        .LIMIT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_xfer),
        .enable  (in_xfer),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GRANT_INSTR;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_wstrb <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            err         <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below
            // are overridden later in the same block to form one-cycle pulses.
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        bus.m_req <= 1'b1;
                        if (grant_data) begin
                            state       <= DXFER;
                            last_grant  <= GRANT_DATA;
                            bus.m_we    <= d_we;
                            bus.m_addr  <= d_addr;
                            bus.m_wdata <= d_wdata;
                            bus.m_wstrb <= (mem_op_e'(d_we) == MEM_OP_STORE) ? d_wstrb : 4'h0;
                        end else begin
                            state       <= IXFER;
                            last_grant  <= GRANT_INSTR;
                            bus.m_we    <= 1'b0;
                            bus.m_addr  <= i_addr + PC_EXT_BASE;
                            bus.m_wdata <= '0;
                            bus.m_wstrb <= 4'h0;
                        end
                    end
                end

                IXFER, DXFER: begin
                    // A response arriving in the expiry cycle still counts.
                    if (bus.m_ack) begin
                        bus.m_req <= 1'b0;
                        state     <= DONE;
                        if (state == DXFER) begin
                            d_ack   <= 1'b1;
                            d_rdata <= bus.m_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= bus.m_rdata;
                        end
                    end else if (expired) begin
                        bus.m_req <= 1'b0;
                        state     <= DONE;
                        err       <= 1'b1;
                        if (state == DXFER) begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end
                    end
                end

                // Ack is visible this cycle; requests are not sampled here.
                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_ext_bus_arb
// Scoreboard bench: each planned transfer (expected bus command, response
// delay, read data, error flag) is queued when stimulus is issued; a bus
// responder answers from the head of the queue and a monitor pops and checks
// it when the corresponding ack appears.
// ---------------------------------------------------------------------------
module tb_ext_bus_arb;

    localparam int unsigned TB_TIMEOUT = 16;
    localparam logic [31:0] TB_PC_BASE = 32'h0000_0800;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
        int          delay;   // negedges after m_req rise; -1 = never ack
    } plan_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        i_ack, d_ack, err;
    logic [31:0] i_rdata, d_rdata;

    ext_bus_arb_if bus ();

    ext_bus_arb #(
        .TIMEOUT     (TB_TIMEOUT),
        .PC_EXT_BASE (TB_PC_BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstrb (d_wstrb),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .err     (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    plan_t plan_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    acks_seen = 0;
    int    stray_req_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_req"},   {31'd0, bus.m_req}, 32'd0);
        check({tag, "_m_we"},    {31'd0, bus.m_we},  32'd0);
        check({tag, "_m_addr"},  bus.m_addr,         32'd0);
        check({tag, "_m_wdata"}, bus.m_wdata,        32'd0);
        check({tag, "_m_wstrb"}, {28'd0, bus.m_wstrb}, 32'd0);
        check({tag, "_i_ack"},   {31'd0, i_ack},     32'd0);
        check({tag, "_d_ack"},   {31'd0, d_ack},     32'd0);
        check({tag, "_err"},     {31'd0, err},       32'd0);
        check({tag, "_i_rdata"}, i_rdata,            32'd0);
        check({tag, "_d_rdata"}, d_rdata,            32'd0);
    endtask

    function automatic void push_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                                       input int delay);
        plan_t p;
        p.is_data = 1'b0; p.addr = exp_addr; p.we = 1'b0; p.wdata = '0; p.wstrb = '0;
        p.err = (delay < 0); p.rdata = (delay < 0) ? 32'd0 : rdata; p.delay = delay;
        plan_q.push_back(p);
    endfunction

    function automatic void push_data(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] wstrb,
                                      input logic [31:0] rdata, input int delay);
        plan_t p;
        p.is_data = 1'b1; p.addr = addr; p.we = we; p.wdata = wdata;
        p.wstrb = we ? wstrb : 4'h0;
        p.err = (delay < 0); p.rdata = (delay < 0) ? 32'd0 : rdata; p.delay = delay;
        plan_q.push_back(p);
    endfunction

    task automatic do_fetch(input logic [31:0] addr);
        int n = 0;
        i_addr = addr;
        i_req  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ack && n < 64);
        if (!i_ack) check("i_ack_wait", 32'd0, 32'd1);
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        int n = 0;
        d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
        d_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 64);
        if (!d_ack) check("d_ack_wait", 32'd0, 32'd1);
        d_req = 1'b0;
    endtask

    // Bus responder: acks the head-of-queue transfer after its planned delay.
    initial begin : responder
        int          resp_cnt = 0;
        int          resp_delay = -1;
        logic [31:0] resp_data = '0;
        bit          resp_active = 1'b0;
        int          stray_done = 0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(negedge clk);
            bus.m_ack = 1'b0;
            if (rst) begin
                resp_active = 1'b0;
            end else if (stray_done != stray_req_cnt && !bus.m_req) begin
                stray_done++;
                bus.m_ack   = 1'b1;
                bus.m_rdata = 32'hDEAD_BEEF;
            end else if (bus.m_req) begin
                if (!resp_active) begin
                    resp_active = 1'b1;
                    resp_cnt    = 0;
                    if (plan_q.size() > 0) begin
                        resp_delay = plan_q[0].delay;
                        resp_data  = plan_q[0].rdata;
                    end else begin
                        resp_delay = -1;
                    end
                end else begin
                    resp_cnt++;
                end
                if (resp_cnt == resp_delay) begin
                    bus.m_ack   = 1'b1;
                    bus.m_rdata = resp_data;
                end
            end else begin
                resp_active = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        logic        prev_req = 1'b0;
        int          req_cycles = 0;
        int          low_cycles = 0;
        bit          had_xfer = 1'b0;
        logic        held_ok = 1'b1;
        logic [68:0] held = '0;
        logic [31:0] last_i = '0;
        logic [31:0] last_d = '0;
        logic [31:0] exp_rd;
        plan_t       p;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0; had_xfer = 1'b0; last_i = '0; last_d = '0;
            end else begin
                if (i_ack && d_ack) check("ack_exclusive", 32'd1, 32'd0);
                if (err && !i_ack && !d_ack) check("err_without_ack", 32'd1, 32'd0);

                if (bus.m_req && !prev_req) begin
                    if (had_xfer) check("gap_min2", {31'd0, low_cycles >= 2}, 32'd1);
                    req_cycles = 1;
                    held_ok    = 1'b1;
                    held       = {bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb};
                    if (plan_q.size() == 0) begin
                        check("unplanned_grant", 32'd1, 32'd0);
                    end else begin
                        p = plan_q[0];
                        check("m_addr",  bus.m_addr,            p.addr);
                        check("m_we",    {31'd0, bus.m_we},     {31'd0, p.we});
                        check("m_wdata", bus.m_wdata,           p.wdata);
                        check("m_wstrb", {28'd0, bus.m_wstrb},  {28'd0, p.wstrb});
                    end
                end else if (bus.m_req) begin
                    req_cycles++;
                    if ({bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== held) held_ok = 1'b0;
                end else begin
                    low_cycles++;
                end

                if (!bus.m_req && prev_req) begin
                    had_xfer   = 1'b1;
                    low_cycles = 1;
                    check("ack_with_mreq_fall", {31'd0, i_ack | d_ack}, 32'd1);
                    check("m_held", {31'd0, held_ok}, 32'd1);
                end

                if (i_ack || d_ack) begin
                    acks_seen++;
                    if (plan_q.size() == 0) begin
                        check("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        p = plan_q.pop_front();
                        exp_rd = p.rdata;
                        check("ack_is_data", {31'd0, d_ack}, {31'd0, p.is_data});
                        check("err",         {31'd0, err},   {31'd0, p.err});
                        check("req_cycles",  req_cycles, p.err ? TB_TIMEOUT : p.delay + 1);
                        if (d_ack) begin
                            check("d_rdata",      d_rdata, exp_rd);
                            check("i_rdata_hold", i_rdata, last_i);
                            last_d = exp_rd;
                        end else begin
                            check("i_rdata",      i_rdata, exp_rd);
                            check("d_rdata_hold", d_rdata, last_d);
                            last_i = exp_rd;
                        end
                    end
                end
                prev_req = bus.m_req;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int acks_before;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic fetch with offset.
        push_fetch(32'h0000_0810, 32'hA5A5_0001, 3);
        do_fetch(32'h0000_0010);
        repeat (3) @(negedge clk);

        // Simultaneous requests from reset: data first, then fetch.
        apply_reset();
        push_data(1'b1, 32'h0000_2000, 32'h1122_3344, 4'hF, 32'h0BAD_0001, 1);
        push_fetch(32'h0000_0020 + TB_PC_BASE, 32'hA5A5_0002, 2);
        fork
            do_data(1'b1, 32'h0000_2000, 32'h1122_3344, 4'hF);
            do_fetch(32'h0000_0020);
        join
        repeat (3) @(negedge clk);

        // Data re-requested continuously with a fetch pending: D I D I D.
        push_data(1'b0, 32'h0000_3000, 32'h5555_0000, 4'hA, 32'hD000_0001, 0);
        push_fetch(32'h0000_0100 + TB_PC_BASE, 32'h1000_0001, 1);
        push_data(1'b1, 32'h0000_3004, 32'h5555_0001, 4'h3, 32'hD000_0002, 2);
        push_fetch(32'h0000_0104 + TB_PC_BASE, 32'h1000_0002, 0);
        push_data(1'b0, 32'h0000_3008, 32'h5555_0002, 4'hC, 32'hD000_0003, 4);
        fork
            begin
                do_data(1'b0, 32'h0000_3000, 32'h5555_0000, 4'hA);
                do_data(1'b1, 32'h0000_3004, 32'h5555_0001, 4'h3);
                do_data(1'b0, 32'h0000_3008, 32'h5555_0002, 4'hC);
            end
            begin
                do_fetch(32'h0000_0100);
                do_fetch(32'h0000_0104);
            end
        join
        repeat (3) @(negedge clk);

        // Timeout on a load: err = 1, d_rdata forced to 0.
        push_data(1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h0, -1);
        do_data(1'b0, 32'h0000_4000, 32'h0, 4'hF);
        repeat (3) @(negedge clk);

        // Stray m_ack while idle must be ignored.
        acks_before = acks_seen;
        stray_req_cnt++;
        repeat (4) @(negedge clk);
        check("stray_no_ack", acks_seen, acks_before);
        check("stray_no_mreq", {31'd0, bus.m_req}, 32'd0);

        // Fetch address wrap-around.
        push_fetch(32'h0000_0100, 32'hCAFE_F00D, 2);
        do_fetch(32'hFFFF_F900);
        repeat (3) @(negedge clk);

        // Reset in the middle of a data transfer.
        push_data(1'b1, 32'h0000_5000, 32'h7777_8888, 4'h5, 32'h0, -1);
        d_we = 1'b1; d_addr = 32'h0000_5000; d_wdata = 32'h7777_8888; d_wstrb = 4'h5;
        d_req = 1'b1;
        n = 0;
        while (!bus.m_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_mreq_seen", {31'd0, bus.m_req}, 32'd1);
        repeat (3) @(negedge clk);
        acks_before = acks_seen;
        rst = 1'b1;
        #1;
        check_all_zero("midxfer_rst");
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        plan_q.delete();
        repeat (4) @(negedge clk);
        check("rst_no_ack", acks_seen, acks_before);

        // After reset: a tie goes to data first again, and both complete.
        push_data(1'b0, 32'h0000_6000, 32'h0, 4'h0, 32'h6060_6060, 2);
        push_fetch(32'h0000_0040 + TB_PC_BASE, 32'h4040_4040, 1);
        fork
            do_data(1'b0, 32'h0000_6000, 32'h0, 4'h0);
            do_fetch(32'h0000_0040);
        join
        repeat (3) @(negedge clk);

        check("plan_drained", plan_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
